word_to_half_serializer: RTL

// - Narrowing counterpart of the 16->32 extend path: accepts one 32-bit store request
//   (data, byte address, size) and emits it as 16-bit beats with byte enables.
// - Sits between the MEM-stage store path and a 16-bit-wide data memory / bus port.
// - valid/ready handshake on both sides. Word stores take two beats; half and byte stores take one.

---
 rtl/word_to_half_serializer_pkg.sv | 17 +
 rtl/word_to_half_serializer_lane_format.sv | 50 +++++
 rtl/word_to_half_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/word_to_half_serializer_pkg.sv
// Shared encodings for the store narrowing path and the load-side extender.
package word_to_half_serializer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } state_e;

endpackage

// File: rtl/word_to_half_serializer_lane_format.sv
// Formats one 16-bit beat of a store request: lane data, byte enables, address offset, legality.
module store_lane_format
    import word_to_half_serializer_pkg::*;
#(
    parameter bit HI_FIRST = 1'b0
) (
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        beat_sel,
    output logic [15:0] out_data,
    output logic [1:0]  out_be,
    output logic [1:0]  addr_ofs,
    output logic        legal
);

    logic w_hi_half;

    // Which word half this beat carries depends on beat order.
    assign w_hi_half = beat_sel ^ HI_FIRST;

    always_comb begin
        out_data = 16'h0000;
        out_be   = 2'b00;
        addr_ofs = 2'd0;
        legal    = 1'b0;
        case (size_e'(size))
            SZ_BYTE: begin
                out_data = {data[7:0], data[7:0]};
                out_be   = addr_lo[0] ? 2'b10 : 2'b01;
                legal    = 1'b1;
            end
            SZ_HALF: begin
                out_data = data[15:0];
                out_be   = 2'b11;
                legal    = ~addr_lo[0];
            end
            SZ_WORD: begin
                out_data = w_hi_half ? data[31:16] : data[15:0];
                out_be   = 2'b11;
                addr_ofs = w_hi_half ? 2'd2 : 2'd0;
                legal    = (addr_lo == 2'b00);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/word_to_half_serializer.sv
// Narrows a 32-bit store request into one or two registered 16-bit beats with byte enables.
module word_to_half_serializer
    import word_to_half_serializer_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter bit          HI_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_be,
    output logic              out_last,
    output logic              misalign_err
);

    state_e            r_state, w_state_d;
    logic              r_out_valid, w_out_valid_d;
    logic [15:0]       r_out_data, w_out_data_d;
    logic [ADDR_W-1:0] r_out_addr, w_out_addr_d;
    logic [1:0]        r_out_be, w_out_be_d;
    logic              r_out_last, w_out_last_d;
    logic              r_err, w_err_d;
    logic [15:0]       r_b1_data, w_b1_data_d;
    logic [ADDR_W-1:0] r_b1_addr, w_b1_addr_d;
    logic [1:0]        r_b1_be, w_b1_be_d;

    logic [15:0]       w_b0_data, w_b1_data;
    logic [1:0]        w_b0_be, w_b1_be;
    logic [1:0]        w_b0_ofs, w_b1_ofs;
    logic              w_b0_legal, w_b1_legal, w_legal;
    logic [ADDR_W-1:0] w_base;
    logic              w_final_hs, w_accept;

    store_lane_format #(
        .HI_FIRST (HI_FIRST)
    ) u_fmt_b0 (
        .data     (in_data),
        .addr_lo  (in_addr[1:0]),
        .size     (in_size),
        .beat_sel (1'b0),
        .out_data (w_b0_data),
        .out_be   (w_b0_be),
        .addr_ofs (w_b0_ofs),
        .legal    (w_b0_legal)
    );

    store_lane_format #(
        .HI_FIRST (HI_FIRST)
    ) u_fmt_b1 (
        .data     (in_data),
        .addr_lo  (in_addr[1:0]),
        .size     (in_size),
        .beat_sel (1'b1),
        .out_data (w_b1_data),
        .out_be   (w_b1_be),
        .addr_ofs (w_b1_ofs),
        .legal    (w_b1_legal)
    );

    assign w_legal    = w_b0_legal & w_b1_legal;
    assign w_base     = {in_addr[ADDR_W-1:1], 1'b0};
    assign w_final_hs = r_out_valid & out_ready & r_out_last;
    assign in_ready   = rst_n & ((r_state == ST_IDLE) | w_final_hs);
    assign w_accept   = in_valid & in_ready;

    always_comb begin
        w_state_d     = r_state;
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
        w_out_addr_d  = r_out_addr;
        w_out_be_d    = r_out_be;
        w_out_last_d  = r_out_last;
        w_err_d       = 1'b0;
        w_b1_data_d   = r_b1_data;
        w_b1_addr_d   = r_b1_addr;
        w_b1_be_d     = r_b1_be;

        case (r_state)
            ST_BEAT0: begin
                if (out_ready) begin
                    if (r_out_last) begin
                        w_state_d     = ST_IDLE;
                        w_out_valid_d = 1'b0;
                    end else begin
                        w_state_d    = ST_BEAT1;
                        w_out_data_d = r_b1_data;
                        w_out_addr_d = r_b1_addr;
                        w_out_be_d   = r_b1_be;
                        w_out_last_d = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (out_ready) begin
                    w_state_d     = ST_IDLE;
                    w_out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // A new accept overrides the retiring beat in the same cycle.
        if (w_accept) begin
            if (w_legal) begin
                w_state_d     = ST_BEAT0;
                w_out_valid_d = 1'b1;
                w_out_data_d  = w_b0_data;
                w_out_addr_d  = w_base + ADDR_W'(w_b0_ofs);
                w_out_be_d    = w_b0_be;
                w_out_last_d  = (size_e'(in_size) != SZ_WORD);
                w_b1_data_d   = w_b1_data;
                w_b1_addr_d   = w_base + ADDR_W'(w_b1_ofs);
                w_b1_be_d     = w_b1_be;
            end else begin
                w_state_d     = ST_IDLE;
                w_out_valid_d = 1'b0;
                w_err_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_be    <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_b1_data   <= '0;
            r_b1_addr   <= '0;
            r_b1_be     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
            r_out_addr  <= w_out_addr_d;
            r_out_be    <= w_out_be_d;
            r_out_last  <= w_out_last_d;
            r_err       <= w_err_d;
            r_b1_data   <= w_b1_data_d;
            r_b1_addr   <= w_b1_addr_d;
            r_b1_be     <= w_b1_be_d;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_addr     = r_out_addr;
    assign out_be       = r_out_be;
    assign out_last     = r_out_last;
    assign misalign_err = r_err;

endmodule
